// File: rtl/softmax_stream_adapter_pkg.sv
// Shared definitions for the softmax stream adapter: element width and a width helper.
package softmax_stream_adapter_pkg;

    localparam int unsigned SM_DW = 16;

    // Bits needed to index 0..value-1; never less than one bit.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned w;
        w = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                w = i + 1;
            end
        end
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/softmax_stream_adapter_vec_fifo.sv
// Synchronous vector FIFO with registered storage, full/empty flags and a combinational head.
module vec_fifo
    import softmax_stream_adapter_pkg::*;
#(
    parameter int unsigned WIDTH = 128,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int unsigned PtrW = clog2(DEPTH);
    localparam int unsigned CntW = clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_wr, do_rd;

    assign full  = (count_q == CntW'(DEPTH));
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];

    // A pop in the same cycle frees the slot, so a write into a full FIFO is still taken.
    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_wr) begin
            wr_ptr_d = (wr_ptr_q == PtrW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (do_rd) begin
            rd_ptr_d = (rd_ptr_q == PtrW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({do_wr, do_rd})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/softmax_stream_adapter.sv
// Element-serial front/back end for the N-wide softmax core, with credit control so that
// every result the core returns has a buffer slot waiting for it.
module softmax_stream_adapter
    import softmax_stream_adapter_pkg::*;
#(
    parameter int unsigned N         = 8,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [SM_DW-1:0]    s_data,
    output logic                sm_valid_in,
    output logic [N*SM_DW-1:0]  sm_in_flat,
    input  logic                sm_valid_out,
    input  logic [N*SM_DW-1:0]  sm_prob_flat,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [SM_DW-1:0]    m_data,
    output logic                m_last,
    output logic                busy,
    output logic                ovf_err
);

    localparam int unsigned IdxW = clog2(N);
    localparam int unsigned CrW  = clog2(BUF_DEPTH + 1);

    logic [IdxW-1:0]    wr_idx_q, wr_idx_d;
    logic [IdxW-1:0]    rd_idx_q, rd_idx_d;
    logic [CrW-1:0]     credits_q, credits_d;
    logic [N*SM_DW-1:0] pack_q, pack_d;
    logic [N*SM_DW-1:0] sm_in_flat_q, sm_in_flat_d;
    logic               sm_valid_in_q;
    logic               ovf_q, ovf_d;
    logic               accept, issue, pop;
    logic               fifo_full, fifo_empty;
    logic [N*SM_DW-1:0] fifo_head;

    vec_fifo #(
        .WIDTH (N * SM_DW),
        .DEPTH (BUF_DEPTH)
    ) u_vec_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (sm_valid_out),
        .wr_data (sm_prob_flat),
        .rd_en   (pop),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .head    (fifo_head)
    );

    // Only the closing element of a vector needs a credit; earlier slots never stall.
    assign s_ready = (wr_idx_q != IdxW'(N - 1)) || (credits_q != '0);
    assign accept  = s_valid && s_ready;
    assign issue   = accept && (wr_idx_q == IdxW'(N - 1));

    assign m_valid = !fifo_empty;
    assign m_last  = (rd_idx_q == IdxW'(N - 1));
    assign m_data  = fifo_head[rd_idx_q*SM_DW +: SM_DW];
    assign pop     = m_valid && m_ready && m_last;

    assign sm_valid_in = sm_valid_in_q;
    assign sm_in_flat  = sm_in_flat_q;
    assign ovf_err     = ovf_q;
    assign busy        = (wr_idx_q != '0) || (credits_q != CrW'(BUF_DEPTH));

    always_comb begin
        pack_d       = pack_q;
        wr_idx_d     = wr_idx_q;
        rd_idx_d     = rd_idx_q;
        sm_in_flat_d = sm_in_flat_q;
        credits_d    = credits_q;
        ovf_d        = ovf_q;
        if (accept) begin
            pack_d[wr_idx_q*SM_DW +: SM_DW] = s_data;
            wr_idx_d = issue ? '0 : wr_idx_q + 1'b1;
        end
        if (issue) begin
            sm_in_flat_d = pack_d;
        end
        if (m_valid && m_ready) begin
            rd_idx_d = m_last ? '0 : rd_idx_q + 1'b1;
        end
        case ({issue, pop})
            2'b10:   credits_d = credits_q - 1'b1;
            2'b01:   credits_d = credits_q + 1'b1;
            default: credits_d = credits_q;
        endcase
        if (sm_valid_out && fifo_full && !pop) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_idx_q      <= '0;
            rd_idx_q      <= '0;
            credits_q     <= CrW'(BUF_DEPTH);
            pack_q        <= '0;
            sm_in_flat_q  <= '0;
            sm_valid_in_q <= 1'b0;
            ovf_q         <= 1'b0;
        end else begin
            wr_idx_q      <= wr_idx_d;
            rd_idx_q      <= rd_idx_d;
            credits_q     <= credits_d;
            pack_q        <= pack_d;
            sm_in_flat_q  <= sm_in_flat_d;
            sm_valid_in_q <= issue;
            ovf_q         <= ovf_d;
        end
    end

endmodule

// File: tb/tb_softmax_stream_adapter.sv
// Scoreboard bench for softmax_stream_adapter with a 5-cycle echo stub standing in for the core.
module tb_softmax_stream_adapter;

    localparam int N  = 8;
    localparam int BD = 2;
    localparam int W  = N * 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         s_valid;
    logic         s_ready;
    logic [15:0]  s_data;
    logic         sm_valid_in;
    logic [W-1:0] sm_in_flat;
    logic         sm_valid_out;
    logic [W-1:0] sm_prob_flat;
    logic         m_valid;
    logic         m_ready;
    logic [15:0]  m_data;
    logic         m_last;
    logic         busy;
    logic         ovf_err;

    softmax_stream_adapter #(
        .N         (N),
        .BUF_DEPTH (BD)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .sm_valid_in  (sm_valid_in),
        .sm_in_flat   (sm_in_flat),
        .sm_valid_out (sm_valid_out),
        .sm_prob_flat (sm_prob_flat),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .m_last       (m_last),
        .busy         (busy),
        .ovf_err      (ovf_err)
    );

    always #5 clk = ~clk;

    // Core stub: echoes each issued vector five cycles later; inj_v forces an extra result.
    logic         pv [5];
    logic [W-1:0] pd [5];
    logic         inj_v;
    logic [W-1:0] inj_d;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 5; i++) pv[i] <= 1'b0;
        end else begin
            pv[0] <= sm_valid_in;
            pd[0] <= sm_in_flat;
            for (int i = 1; i < 5; i++) begin
                pv[i] <= pv[i-1];
                pd[i] <= pd[i-1];
            end
        end
    end

    assign sm_valid_out = pv[4] | inj_v;
    assign sm_prob_flat = inj_v ? inj_d : pd[4];

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_issue  = 0;
    int          exp_issue = 0;
    int          part = 0;
    logic [15:0] vec [N];
    logic [16:0] sb [$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: every output handshake is compared against the next scoreboard entry.
    always @(negedge clk) begin
        if (!rst && m_valid && m_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: got data %h last %b, expected nothing", m_data,
                         m_last);
            end else begin
                check("m_stream", 128'({m_last, m_data}), 128'(sb.pop_front()));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && sm_valid_in) n_issue++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic record(input logic [15:0] d);
        vec[part] = d;
        part++;
        if (part == N) begin
            for (int k = 0; k < N; k++) sb.push_back({(k == N - 1), vec[k]});
            part = 0;
            exp_issue++;
        end
    endtask

    task automatic send(input logic [15:0] d);
        int n;
        n = 0;
        s_valid = 1'b1;
        s_data  = d;
        while (!s_ready && n < 200) begin
            step();
            n++;
        end
        if (!s_ready) begin
            check("send_timeout", 128'(s_ready), 128'(1));
            s_valid = 1'b0;
        end else begin
            step();
            s_valid = 1'b0;
            record(d);
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            step();
            n++;
        end
        check("drain", 128'(sb.size()), 128'(0));
        step();
        step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b0; inj_v = 1'b0; inj_d = '0;

        // Reset state
        step();
        step();
        check("rst_sm_valid_in", 128'(sm_valid_in), 128'(0));
        check("rst_sm_in_flat", 128'(sm_in_flat), 128'(0));
        check("rst_m_valid", 128'(m_valid), 128'(0));
        check("rst_m_last", 128'(m_last), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_ovf_err", 128'(ovf_err), 128'(0));
        check("rst_s_ready", 128'(s_ready), 128'(1));
        rst = 1'b0;
        step();
        check("post_rst_busy", 128'(busy), 128'(0));
        check("post_rst_s_ready", 128'(s_ready), 128'(1));

        // Single vector, back-to-back
        m_ready = 1'b1;
        for (int i = 1; i <= N; i++) send(16'(i * 16'h0100));
        check("issue_pulse", 128'(sm_valid_in), 128'(1));
        check("flat_elem0", 128'(sm_in_flat[15:0]), 128'(16'h0100));
        check("flat_elem7", 128'(sm_in_flat[127:112]), 128'(16'h0800));
        step();
        check("issue_pulse_end", 128'(sm_valid_in), 128'(0));
        wait_drain();

        // Credit stall on the last element of vector 3
        m_ready = 1'b0;
        for (int i = 0; i < 23; i++) send(16'h1000 + 16'(i));
        s_valid = 1'b1;
        s_data  = 16'h1017;
        for (int k = 0; k < 10; k++) begin
            step();
            check("stall_s_ready", 128'(s_ready), 128'(0));
        end
        m_ready = 1'b1;
        for (int k = 1; k <= N; k++) begin
            step();
            check("resume_s_ready", 128'(s_ready), 128'(k == N));
        end
        step();
        s_valid = 1'b0;
        record(16'h1017);
        wait_drain();

        // Issue coinciding with the final output handshake of a buffered vector
        m_ready = 1'b0;
        for (int i = 0; i < N; i++) send(16'h2000 + 16'(i));
        repeat (8) step();
        for (int i = 0; i < N - 1; i++) send(16'h2100 + 16'(i));
        m_ready = 1'b1;
        repeat (N - 1) step();
        s_valid = 1'b1;
        s_data  = 16'h2107;
        step();
        s_valid = 1'b0;
        m_ready = 1'b0;
        record(16'h2107);
        check("coincide_issue", 128'(sm_valid_in), 128'(1));
        check("coincide_busy", 128'(busy), 128'(1));
        // One credit must remain: a further vector issues, the one after stalls
        for (int i = 0; i < N; i++) send(16'h2200 + 16'(i));
        for (int i = 0; i < N - 1; i++) send(16'h2300 + 16'(i));
        s_valid = 1'b1;
        s_data  = 16'h2307;
        for (int k = 0; k < 12; k++) begin
            step();
            check("credits_exhausted", 128'(s_ready), 128'(0));
        end
        check("no_ovf_yet", 128'(ovf_err), 128'(0));
        check("fifo_has_data", 128'(m_valid), 128'(1));

        // Forced result into a full FIFO
        inj_d = {8{16'hDEAD}};
        inj_v = 1'b1;
        step();
        inj_v = 1'b0;
        step();
        check("ovf_set", 128'(ovf_err), 128'(1));
        m_ready = 1'b1;
        send(16'h2307);
        repeat (3) step();
        check("ovf_sticky", 128'(ovf_err), 128'(1));
        wait_drain();
        check("ovf_sticky_end", 128'(ovf_err), 128'(1));

        // Reset discards a partial vector
        for (int i = 0; i < 4; i++) send(16'h5000 + 16'(i));
        rst = 1'b1;
        step();
        rst = 1'b0;
        part = 0;
        step();
        check("mid_rst_busy", 128'(busy), 128'(0));
        check("mid_rst_flat", 128'(sm_in_flat), 128'(0));
        check("mid_rst_ovf", 128'(ovf_err), 128'(0));
        for (int i = 1; i <= N; i++) send(16'h6000 + 16'(i));
        check("post_rst_elem0", 128'(sm_in_flat[15:0]), 128'(16'h6001));
        check("post_rst_issue", 128'(sm_valid_in), 128'(1));
        wait_drain();

        check("issue_count", 128'(n_issue), 128'(exp_issue));
        check("idle_at_end", 128'(busy), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
